// File: rtl/avalon_slave_regfile_if.sv
// Avalon-MM bus bundle between the master stage and the register-file slave.
interface avalon_slave_regfile_if #(
   parameter int unsigned ADDR_W = 4,
   parameter int unsigned DATA_W = 4
);
   logic [ADDR_W-1:0] address;
   logic              write;
   logic [DATA_W-1:0] writedata;
   logic              read;
   logic [DATA_W-1:0] readdata;
   logic              waitrequest;

   modport master (
      output address, write, writedata, read,
      input  readdata, waitrequest
   );

   modport slave (
      input  address, write, writedata, read,
      output readdata, waitrequest
   );
endinterface

// File: rtl/avalon_slave_regfile.sv
// Avalon-MM register-file slave with programmable wait states, a committed-write
// counter and a sticky flag for master protocol violations.
module avalon_slave_regfile #(
   parameter int unsigned ADDR_W      = 4,
   parameter int unsigned DATA_W      = 4,
   parameter int unsigned WAIT_STATES = 1,
   parameter int unsigned COUNT_W     = 8
) (
   input  logic                      clock,
   input  logic                      reset_n,
   avalon_slave_regfile_if.slave     bus,
   output logic [COUNT_W-1:0]        write_count,
   output logic                      protocol_error
);
   localparam int unsigned DEPTH = 2 ** ADDR_W;
   localparam logic [7:0]  CNT_INIT = (WAIT_STATES > 0) ? 8'(WAIT_STATES - 1) : 8'd0;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_ACK
   } state_e;

   state_e              state_q, state_d;
   logic [7:0]          cnt_q, cnt_d;
   logic                is_wr_q, is_wr_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic [DATA_W-1:0]   regs_q [DEPTH];
   logic [DATA_W-1:0]   regs_d [DEPTH];
   logic [COUNT_W-1:0]  count_q, count_d;
   logic                err_q, err_d;
   logic                wait_q, wait_d;
   logic                req;

   assign req = bus.write | bus.read;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      is_wr_d = is_wr_q;
      addr_d  = addr_q;
      rdata_d = rdata_q;
      regs_d  = regs_q;
      count_d = count_q;
      err_d   = err_q;

      if (bus.write && bus.read) err_d = 1'b1;

      case (state_q)
         ST_IDLE: begin
            if (req) begin
               // write wins when both strobes are high
               is_wr_d = bus.write;
               addr_d  = bus.address;
               if (WAIT_STATES == 0) begin
                  state_d = ST_ACK;
                  if (!bus.write) rdata_d = regs_q[bus.address];
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = CNT_INIT;
               end
            end
         end
         ST_WAIT: begin
            if (!req || (bus.write != is_wr_q)) begin
               state_d = ST_IDLE;
               err_d   = 1'b1;
            end else begin
               if (bus.address != addr_q) err_d = 1'b1;
               addr_d = bus.address;
               if (cnt_q == 8'd0) begin
                  state_d = ST_ACK;
                  if (!is_wr_q) rdata_d = regs_q[bus.address];
               end else begin
                  cnt_d = cnt_q - 8'd1;
               end
            end
         end
         ST_ACK: begin
            state_d = ST_IDLE;
            if (!req || (bus.write != is_wr_q)) begin
               err_d = 1'b1;
            end else if (is_wr_q) begin
               regs_d[bus.address] = bus.writedata;
               count_d             = count_q + COUNT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      wait_d = (state_d != ST_ACK);
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         is_wr_q <= 1'b0;
         addr_q  <= '0;
         rdata_q <= '0;
         regs_q  <= '{default: '0};
         count_q <= '0;
         err_q   <= 1'b0;
         wait_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         is_wr_q <= is_wr_d;
         addr_q  <= addr_d;
         rdata_q <= rdata_d;
         regs_q  <= regs_d;
         count_q <= count_d;
         err_q   <= err_d;
         wait_q  <= wait_d;
      end
   end

   assign bus.readdata    = rdata_q;
   assign bus.waitrequest = wait_q;
   assign write_count     = count_q;
   assign protocol_error  = err_q;
endmodule
